// File: rtl/uart_bus_master.sv
// UART byte-stream to SoC bus bridge: decodes 'W'/'R' frames, issues one 32-bit
// access per frame and streams the response bytes back to the UART transmitter.
//
// state  | meaning
// IDLE   | waiting for an opcode byte
// ADDR   | collecting 4 address bytes, MSB first
// DATA   | collecting 4 write-data bytes, MSB first
// ACCESS | single bus_en cycle
// WAIT   | counting read latency, then capture bus_din
// RESP   | streaming the response buffer to tx, MSB first
module uart_bus_master #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RD_LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_dout,
  output logic [3:0]  bus_we,
  output logic        bus_en,
  input  logic [31:0] bus_din,
  output logic        busy,
  output logic        overrun
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES);
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, ACCESS, WAIT, RESP} state_t;

  state_t          state, stateNext;
  logic            isWrite, isWriteNext;
  logic [1:0]      byteCnt, byteCntNext;
  logic [31:0]     addr, addrNext;
  logic [31:0]     wdata, wdataNext;
  logic [31:0]     respBuf, respBufNext;
  logic [2:0]      respLen, respLenNext;
  logic [2:0]      waitCnt, waitCntNext;
  logic [TO_W-1:0] toCnt, toCntNext;
  logic            txValidNext, busEnNext, busyNext, overrunNext;
  logic [7:0]      txDataNext;
  logic [31:0]     busAddrNext, busDoutNext;
  logic [3:0]      busWeNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      isWrite  <= 1'b0;
      byteCnt  <= '0;
      addr     <= '0;
      wdata    <= '0;
      respBuf  <= '0;
      respLen  <= '0;
      waitCnt  <= '0;
      toCnt    <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      bus_en   <= 1'b0;
      bus_we   <= '0;
      bus_addr <= '0;
      bus_dout <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= stateNext;
      isWrite  <= isWriteNext;
      byteCnt  <= byteCntNext;
      addr     <= addrNext;
      wdata    <= wdataNext;
      respBuf  <= respBufNext;
      respLen  <= respLenNext;
      waitCnt  <= waitCntNext;
      toCnt    <= toCntNext;
      tx_valid <= txValidNext;
      tx_data  <= txDataNext;
      bus_en   <= busEnNext;
      bus_we   <= busWeNext;
      bus_addr <= busAddrNext;
      bus_dout <= busDoutNext;
      busy     <= busyNext;
      overrun  <= overrunNext;
    end
  end

  always_comb begin
    stateNext   = state;
    isWriteNext = isWrite;
    byteCntNext = byteCnt;
    addrNext    = addr;
    wdataNext   = wdata;
    respBufNext = respBuf;
    respLenNext = respLen;
    waitCntNext = waitCnt;
    toCntNext   = toCnt;
    overrunNext = 1'b0;

    case (state)
      IDLE: begin
        byteCntNext = '0;
        if (rx_valid) begin
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            isWriteNext = (rx_data == OP_WRITE);
            toCntNext   = TO_LOAD;
            stateNext   = ADDR;
          end else begin
            respBufNext = {RSP_NAK, 24'h0};
            respLenNext = 3'd1;
            stateNext   = RESP;
          end
        end
      end
      ADDR, DATA: begin
        if (rx_valid) begin
          toCntNext   = TO_LOAD;
          byteCntNext = byteCnt + 2'd1;
          if (state == ADDR) addrNext = {addr[23:0], rx_data};
          else               wdataNext = {wdata[23:0], rx_data};
          if (byteCnt == 2'd3) stateNext = (state == ADDR && isWrite) ? DATA : ACCESS;
        end else if (toCnt <= TO_W'(1)) begin
          // silent abort: partial frame is discarded without a response
          stateNext   = IDLE;
          byteCntNext = '0;
        end else begin
          toCntNext = toCnt - TO_W'(1);
        end
      end
      ACCESS: begin
        overrunNext = rx_valid;
        if (isWrite) begin
          respBufNext = {RSP_ACK, 24'h0};
          respLenNext = 3'd1;
          stateNext   = RESP;
        end else begin
          waitCntNext = 3'd1;
          stateNext   = WAIT;
        end
      end
      WAIT: begin
        overrunNext = rx_valid;
        if (waitCnt == 3'(RD_LATENCY)) begin
          respBufNext = bus_din;
          respLenNext = 3'd4;
          stateNext   = RESP;
        end else begin
          waitCntNext = waitCnt + 3'd1;
        end
      end
      RESP: begin
        overrunNext = rx_valid;
        if (tx_valid && tx_ready) begin
          respBufNext = {respBuf[23:0], 8'h0};
          respLenNext = respLen - 3'd1;
          if (respLen == 3'd1) stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    if (stateNext != ADDR && stateNext != DATA) toCntNext = '0;

    // outputs are registered copies of what the next state presents
    txValidNext = (stateNext == RESP);
    txDataNext  = (stateNext == RESP) ? respBufNext[31:24] : tx_data;
    busEnNext   = (stateNext == ACCESS);
    busWeNext   = (stateNext == ACCESS && isWriteNext) ? 4'hF : 4'h0;
    busAddrNext = (stateNext == ACCESS) ? addrNext : bus_addr;
    busDoutNext = (stateNext == ACCESS && isWriteNext) ? wdataNext : bus_dout;
    busyNext    = (stateNext != IDLE);
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Randomized and directed bench for uart_bus_master against a frame-level
// reference model (expected bus ops and tx bytes per frame).
module tb_uart_bus_master;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic [31:0] bus_addr;
  logic [31:0] bus_dout;
  logic [3:0]  bus_we;
  logic        bus_en;
  logic [31:0] bus_din;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  uart_bus_master #(.TIMEOUT_CYCLES(TO), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_we(bus_we), .bus_en(bus_en),
    .bus_din(bus_din), .busy(busy), .overrun(overrun)
  );

  typedef struct {logic [31:0] a; logic [3:0] we; logic [31:0] d;} busOp_t;

  int          total = 0;
  int          bad = 0;
  busOp_t      busGot[$];
  busOp_t      busExp[$];
  logic [7:0]  txGot[$];
  logic [7:0]  txExp[$];
  logic [31:0] busMem[logic [31:0]];
  logic [31:0] refMem[logic [31:0]];
  logic [31:0] lastDout;
  int          overrunCnt = 0;
  int          stallErrs = 0;
  int          weErrs = 0;
  int          readyMode = 0;
  int          cyc = 0;
  logic        rdValid = 1'b0;
  logic [31:0] rdData = '0;
  logic        stallPrev = 1'b0;
  logic [7:0]  stallData = '0;
  busOp_t      monOp;

  assign bus_din = rdValid ? rdData : 32'hBAD0_BAD0;

  function automatic logic [31:0] initVal(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [31:0] busRead(input logic [31:0] a);
    return busMem.exists(a) ? busMem[a] : initVal(a);
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initVal(a);
  endfunction

  // bus slave: read data valid only in the single cycle after bus_en
  initial forever begin
    @(posedge clk);
    rdValid <= bus_en && (bus_we == 4'h0);
    rdData  <= busRead(bus_addr);
  end

  initial forever begin
    @(negedge clk);
    if (bus_en) begin
      monOp.a  = bus_addr;
      monOp.we = bus_we;
      monOp.d  = bus_dout;
      busGot.push_back(monOp);
      if (bus_we == 4'hF) busMem[bus_addr] = bus_dout;
    end
    if (!bus_en && bus_we != 4'h0) weErrs++;
    if (tx_valid && tx_ready) txGot.push_back(tx_data);
    if (stallPrev && tx_valid && tx_data !== stallData) stallErrs++;
    stallPrev = tx_valid && !tx_ready;
    stallData = tx_data;
    if (overrun) overrunCnt++;
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (readyMode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ((cyc % 3) == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic checkFrame(input string tag);
    check({tag, "_busN"}, 32'(busGot.size()), 32'(busExp.size()));
    for (int i = 0; i < busGot.size() && i < busExp.size(); i++) begin
      check({tag, "_addr"}, busGot[i].a, busExp[i].a);
      check({tag, "_we"}, 32'(busGot[i].we), 32'(busExp[i].we));
      check({tag, "_dout"}, busGot[i].d, busExp[i].d);
    end
    check({tag, "_txN"}, 32'(txGot.size()), 32'(txExp.size()));
    for (int i = 0; i < txGot.size() && i < txExp.size(); i++)
      check({tag, "_tx"}, 32'(txGot[i]), 32'(txExp[i]));
    busGot.delete(); busExp.delete(); txGot.delete(); txExp.delete();
  endtask

  task automatic doFrame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                         input int maxGap, input bit injectWait, input string tag);
    busOp_t      e;
    logic [31:0] v;
    sendByte(op, $urandom_range(0, maxGap));
    if (op == 8'h57 || op == 8'h52)
      for (int i = 3; i >= 0; i--) sendByte(a[8*i +: 8], $urandom_range(0, maxGap));
    if (op == 8'h57)
      for (int i = 3; i >= 0; i--) sendByte(d[8*i +: 8], $urandom_range(0, maxGap));
    if (op == 8'h57) begin
      e.a = a; e.we = 4'hF; e.d = d;
      busExp.push_back(e);
      refMem[a] = d;
      lastDout = d;
      txExp.push_back(8'h06);
    end else if (op == 8'h52) begin
      e.a = a; e.we = 4'h0; e.d = lastDout;
      busExp.push_back(e);
      v = refRead(a);
      for (int i = 3; i >= 0; i--) txExp.push_back(v[8*i +: 8]);
    end else begin
      txExp.push_back(8'h15);
    end
    if (injectWait) begin
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = 8'h57;
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
    waitIdle(tag);
    checkFrame(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int          n;
    int          ov0;
    logic [31:0] v;
    logic [31:0] pool [5];
    logic [7:0]  op;
    busOp_t      e;

    pool[0] = 32'h0000_0100; pool[1] = 32'h0000_0104; pool[2] = 32'h0000_0200;
    pool[3] = 32'h0000_0004; pool[4] = 32'h0000_0008;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; lastDout = '0;
    busMem[32'h4] = 32'h1234_5678;
    refMem[32'h4] = 32'h1234_5678;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txValid", 32'(tx_valid), 32'd0);
    check("rst_txData", 32'(tx_data), 32'd0);
    check("rst_busEn", 32'(bus_en), 32'd0);
    check("rst_busWe", 32'(bus_we), 32'd0);
    check("rst_busAddr", bus_addr, 32'd0);
    check("rst_busDout", bus_dout, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    readyMode = 0;
    doFrame(8'h57, 32'h8000_1000, 32'hDEAD_BEEF, 0, 1'b0, "wr1");
    doFrame(8'h52, 32'h0000_0004, 32'h0, 0, 1'b0, "rd1");

    readyMode = 1;
    doFrame(8'h52, 32'h8000_1000, 32'h0, 0, 1'b0, "rdStall");
    check("stallHold", 32'(stallErrs), 32'd0);

    readyMode = 0;
    doFrame(8'h41, 32'h0, 32'h0, 0, 1'b0, "nak");
    doFrame(8'h52, 32'h0000_0004, 32'h0, 0, 1'b0, "rdAfterNak");

    sendByte(8'h57, 0);
    sendByte(8'h80, 0);
    sendByte(8'h00, 0);
    repeat (25) begin @(posedge clk); #1; end
    check("toIdle", 32'(busy), 32'd0);
    check("toNoBus", 32'(busGot.size()), 32'd0);
    check("toNoTx", 32'(txGot.size()), 32'd0);
    doFrame(8'h52, 32'h0000_0008, 32'h0, 0, 1'b0, "rdAfterTo");

    ov0 = overrunCnt;
    doFrame(8'h52, 32'h8000_1000, 32'h0, 0, 1'b1, "rdOvr");
    check("ovrCount", 32'(overrunCnt - ov0), 32'd1);

    sendByte(8'h52, 0);
    for (int i = 3; i >= 0; i--) sendByte(8'(32'h10 >> (8*i)), 0);
    v = refRead(32'h10);
    n = 0;
    while (tx_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("rstRespSeen", 32'(tx_valid), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rstMid_txValid", 32'(tx_valid), 32'd0);
    check("rstMid_txData", 32'(tx_data), 32'd0);
    check("rstMid_busy", 32'(busy), 32'd0);
    check("rstMid_busDout", bus_dout, 32'd0);
    @(negedge clk);
    check("rstMid_txN", 32'(txGot.size()), 32'd2);
    if (txGot.size() >= 2) begin
      check("rstMid_tx0", 32'(txGot[0]), 32'(v[31:24]));
      check("rstMid_tx1", 32'(txGot[1]), 32'(v[23:16]));
    end
    check("rstMid_busN", 32'(busGot.size()), 32'd1);
    busGot.delete(); busExp.delete(); txGot.delete(); txExp.delete();
    lastDout = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    doFrame(8'h57, 32'h0000_0010, $urandom, 0, 1'b0, "wrAfterRst");

    for (int k = 0; k < 16; k++) begin
      readyMode = $urandom_range(0, 2);
      case ($urandom_range(0, 7))
        0:       op = 8'($urandom_range(0, 255));
        1, 2, 3: op = 8'h57;
        default: op = 8'h52;
      endcase
      if (op != 8'h57 && op != 8'h52 && (op == 8'h57 || op == 8'h52)) op = 8'h41;
      doFrame(op, pool[$urandom_range(0, 4)], $urandom, 3, 1'b0, "rnd");
    end
    readyMode = 0;

    check("weOnlyInAccess", 32'(weErrs), 32'd0);
    check("stallHoldAll", 32'(stallErrs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
